// File: rtl/adau1761_cfg_pkg.sv
// Shared definitions for the ADAU1761 configuration sequencer.
// Contents: sequencer state enum, configuration ROM entry layout, table end marker,
// default codec device address and small helpers that split a ROM entry into fields.
package adau1761_cfg_pkg;

  localparam int unsigned RegAddrW = 16;
  localparam int unsigned RegDataW = 8;

  // ROM entry layout: {reg_addr[15:0], data[7:0]}
  localparam int unsigned RomRegMsb  = 23;
  localparam int unsigned RomRegLsb  = 8;
  localparam int unsigned RomDataMsb = 7;
  localparam int unsigned RomDataLsb = 0;

  localparam logic [RegAddrW-1:0] EndMark        = 16'hFFFF;
  localparam logic [6:0]          DefaultDevAddr = 7'h3B;

  typedef enum logic [2:0] {
    StStartup,
    StFetch,
    StFetchWait,
    StBootIssue,
    StBootWait,
    StIdle,
    StHostIssue,
    StHostWait
  } cfg_state_e;

  function automatic logic [RegAddrW-1:0] rom_reg_addr(input logic [23:0] entry);
    return entry[RomRegMsb:RomRegLsb];
  endfunction

  function automatic logic [RegDataW-1:0] rom_reg_data(input logic [23:0] entry);
    return entry[RomDataMsb:RomDataLsb];
  endfunction

endpackage

// File: rtl/adau1761_cfg_sequencer_issuer.sv
// cfg_retry_issuer: command register, valid/ready handshake and NACK retry counter shared by
// the boot and host paths of the sequencer.
// Ports:
//   load/sel_host        capture command fields from the boot (ROM) or host source
//   issue_next           owner will be in an ISSUE state next cycle (drives registered m_valid)
//   in_wait              owner is in a WAIT state; m_done is only honoured then
//   accept               m_valid & m_ready this cycle
//   done_ok/do_retry/failed  decoded completion of the outstanding command
//   m_*                  command interface towards the I2C master
module cfg_retry_issuer
  import adau1761_cfg_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                sel_host,
  input  logic [RegAddrW-1:0] boot_reg_addr,
  input  logic [RegDataW-1:0] boot_data,
  input  logic [RegAddrW-1:0] host_reg_addr,
  input  logic [RegDataW-1:0] host_data,
  input  logic                issue_next,
  input  logic                in_wait,
  output logic                accept,
  output logic                done_ok,
  output logic                do_retry,
  output logic                failed,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [RegAddrW-1:0] m_reg_addr,
  output logic [RegDataW-1:0] m_data,
  input  logic                m_done,
  input  logic                m_nack
);

  localparam int unsigned RetryW = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RetryW-1:0] RetryLimit = RetryW'(MAX_RETRY);

  logic [RetryW-1:0]   retry_q, retry_d;
  logic [RegAddrW-1:0] reg_q, reg_d;
  logic [RegDataW-1:0] data_q, data_d;
  logic                valid_q;
  logic                nack_done;

  assign accept    = valid_q & m_ready;
  assign done_ok   = in_wait & m_done & ~m_nack;
  assign nack_done = in_wait & m_done & m_nack;
  assign do_retry  = nack_done & (retry_q < RetryLimit);
  assign failed    = nack_done & (retry_q >= RetryLimit);

  assign m_valid    = valid_q;
  assign m_reg_addr = reg_q;
  assign m_data     = data_q;

  always_comb begin
    retry_d = retry_q;
    reg_d   = reg_q;
    data_d  = data_q;
    if (load) begin
      reg_d   = sel_host ? host_reg_addr : boot_reg_addr;
      data_d  = sel_host ? host_data : boot_data;
      retry_d = '0;
    end
    // Fields are left untouched on retry so the re-issue is identical.
    if (done_ok || failed) begin
      retry_d = '0;
    end else if (do_retry) begin
      retry_d = retry_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_q <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      valid_q <= issue_next;
    end
  end

endmodule

// File: rtl/adau1761_cfg_sequencer.sv
// adau1761_cfg_sequencer: boots the ADAU1761 by walking a register ROM and issuing one I2C
// register write per entry, then hands the I2C write master to a runtime host port.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rom_addr/rom_data     configuration ROM (data valid one cycle after address)
//   host_*                runtime write request port and completion pulses
//   m_*                   command/handshake towards the byte-level I2C write master
//   boot_done/boot_error  sticky boot status; busy is high outside IDLE
module adau1761_cfg_sequencer
  import adau1761_cfg_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = DefaultDevAddr,
  parameter int unsigned ROM_ADDR_W     = 10,
  parameter int unsigned STARTUP_CYCLES = 48000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [15:0] END_MARK       = EndMark
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [23:0]           rom_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [15:0]           host_reg_addr,
  input  logic [7:0]            host_reg_data,
  output logic                  host_done,
  output logic                  host_err,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [6:0]            m_dev_addr,
  output logic [15:0]           m_reg_addr,
  output logic [7:0]            m_data,
  input  logic                  m_done,
  input  logic                  m_nack,
  output logic                  boot_done,
  output logic                  boot_error,
  output logic                  busy
);

  localparam int unsigned CntW       = (STARTUP_CYCLES == 0) ? 1 : $clog2(STARTUP_CYCLES + 1);
  // 0 and 1 both leave STARTUP after a single cycle.
  localparam int unsigned LastCntInt = (STARTUP_CYCLES <= 1) ? 0 : STARTUP_CYCLES - 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(LastCntInt);

  cfg_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ROM_ADDR_W-1:0] idx_q, idx_d;
  logic                  boot_done_q, boot_done_d;
  logic                  boot_error_q, boot_error_d;
  logic                  host_done_q, host_done_d;
  logic                  host_err_q, host_err_d;

  logic load, sel_host, issue_next, in_wait;
  logic accept, done_ok, do_retry, failed;

  assign m_dev_addr = DEV_ADDR;
  assign rom_addr   = idx_q;
  assign host_ready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign host_done  = host_done_q;
  assign host_err   = host_err_q;
  assign boot_done  = boot_done_q;
  assign boot_error = boot_error_q;

  assign issue_next = (state_d == StBootIssue) || (state_d == StHostIssue);
  assign in_wait    = (state_q == StBootWait) || (state_q == StHostWait);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    boot_done_d  = boot_done_q;
    boot_error_d = boot_error_q;
    host_done_d  = 1'b0;
    host_err_d   = 1'b0;
    load         = 1'b0;
    sel_host     = 1'b0;

    unique case (state_q)
      StStartup: begin
        if (cnt_q == LastCnt) begin
          state_d = StFetch;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFetch: state_d = StFetchWait;
      StFetchWait: begin
        if (rom_reg_addr(rom_data) == END_MARK) begin
          boot_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          load    = 1'b1;
          state_d = StBootIssue;
        end
      end
      StBootIssue: if (accept) state_d = StBootWait;
      StBootWait: begin
        if (done_ok) begin
          // The last ROM slot ends the table; the index never wraps back to 0.
          if (idx_q == {ROM_ADDR_W{1'b1}}) begin
            boot_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StFetch;
          end
        end else if (do_retry) begin
          state_d = StBootIssue;
        end else if (failed) begin
          boot_error_d = 1'b1;
          state_d      = StIdle;
        end
      end
      StIdle: begin
        if (host_valid) begin
          load     = 1'b1;
          sel_host = 1'b1;
          state_d  = StHostIssue;
        end
      end
      StHostIssue: if (accept) state_d = StHostWait;
      StHostWait: begin
        if (done_ok) begin
          host_done_d = 1'b1;
          state_d     = StIdle;
        end else if (do_retry) begin
          state_d = StHostIssue;
        end else if (failed) begin
          host_done_d = 1'b1;
          host_err_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StStartup;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StStartup;
      cnt_q        <= '0;
      idx_q        <= '0;
      boot_done_q  <= 1'b0;
      boot_error_q <= 1'b0;
      host_done_q  <= 1'b0;
      host_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      boot_done_q  <= boot_done_d;
      boot_error_q <= boot_error_d;
      host_done_q  <= host_done_d;
      host_err_q   <= host_err_d;
    end
  end

  cfg_retry_issuer #(
    .MAX_RETRY(MAX_RETRY)
  ) u_issuer (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .sel_host     (sel_host),
    .boot_reg_addr(rom_reg_addr(rom_data)),
    .boot_data    (rom_reg_data(rom_data)),
    .host_reg_addr(host_reg_addr),
    .host_data    (host_reg_data),
    .issue_next   (issue_next),
    .in_wait      (in_wait),
    .accept       (accept),
    .done_ok      (done_ok),
    .do_retry     (do_retry),
    .failed       (failed),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_reg_addr   (m_reg_addr),
    .m_data       (m_data),
    .m_done       (m_done),
    .m_nack       (m_nack)
  );

endmodule

// File: tb/tb_adau1761_cfg_sequencer.sv
// Scoreboard bench for adau1761_cfg_sequencer: a reference model derives the expected I2C
// command stream from ROM contents and a per-entry NACK plan; a monitor pops and compares.
module tb_adau1761_cfg_sequencer;

  localparam int unsigned Aw       = 4;
  localparam int unsigned Depth    = 16;
  localparam int unsigned Startup  = 10;
  localparam int unsigned MaxRetry = 3;
  localparam logic [6:0]  Dev      = 7'h3B;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [Aw-1:0] rom_addr;
  logic [23:0]   rom_data;
  logic          host_valid, host_ready, host_done, host_err;
  logic [15:0]   host_reg_addr;
  logic [7:0]    host_reg_data;
  logic          m_valid, m_ready, m_done, m_nack;
  logic [6:0]    m_dev_addr;
  logic [15:0]   m_reg_addr;
  logic [7:0]    m_data;
  logic          boot_done, boot_error, busy;

  adau1761_cfg_sequencer #(
    .DEV_ADDR      (Dev),
    .ROM_ADDR_W    (Aw),
    .STARTUP_CYCLES(Startup),
    .MAX_RETRY     (MaxRetry),
    .END_MARK      (16'hFFFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .host_reg_addr(host_reg_addr),
    .host_reg_data(host_reg_data),
    .host_done    (host_done),
    .host_err     (host_err),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_dev_addr   (m_dev_addr),
    .m_reg_addr   (m_reg_addr),
    .m_data       (m_data),
    .m_done       (m_done),
    .m_nack       (m_nack),
    .boot_done    (boot_done),
    .boot_error   (boot_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  logic [23:0] rom [Depth];
  int          nk_tab [Depth];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] exp_cmd[$];
  bit          exp_host[$];
  bit          resp_q[$];
  bit          exp_bd, exp_be;

  int ready_mode   = 0;
  int hold_ready   = 0;
  int done_dly_min = 0;
  int done_dly_max = 0;
  bit spurious_req = 0;
  int accepts      = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: boot walks the ROM until the end marker, one command per attempt.
  task automatic plan_boot();
    logic [23:0] ent;
    exp_bd = 0;
    exp_be = 0;
    for (int i = 0; i < Depth; i++) begin
      ent = rom[i];
      if (ent[23:8] == 16'hFFFF) begin
        exp_bd = 1;
        break;
      end
      for (int a = 0; a <= nk_tab[i] && a <= MaxRetry; a++) begin
        exp_cmd.push_back(ent);
        resp_q.push_back(a < nk_tab[i]);
      end
      if (nk_tab[i] > MaxRetry) begin
        exp_be = 1;
        break;
      end
      if (i == Depth - 1) exp_bd = 1;
    end
  endtask

  // Master model: random ready, done 1+ cycles after accept, NACK bits from resp_q.
  initial begin : master
    bit pend;
    bit nk;
    int dly;
    pend = 0;
    nk = 0;
    dly = 0;
    m_ready = 0;
    m_done = 0;
    m_nack = 0;
    forever begin
      @(negedge clk);
      m_done = 0;
      m_nack = 0;
      if (reset) begin
        pend = 0;
        m_ready = 0;
      end else begin
        if (spurious_req) begin
          m_done = 1;
          m_nack = 1'($urandom_range(0, 1));
          spurious_req = 0;
        end else if (pend) begin
          if (dly == 0) begin
            m_done = 1;
            m_nack = nk;
            pend = 0;
          end else begin
            dly--;
          end
        end
        if (m_valid && hold_ready > 0) begin
          m_ready = 0;
          hold_ready--;
        end else begin
          m_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
        if (m_valid && m_ready) begin
          pend = 1;
          dly = $urandom_range(done_dly_min, done_dly_max);
          nk = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic [23:0] prev, got, e;
    bit stalled, eh;
    stalled = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        stalled = 0;
      end else begin
        got = {m_reg_addr, m_data};
        if (m_valid) begin
          if (stalled) check_eq("stall_fields_stable", got, prev);
          if (m_ready) begin
            accepts++;
            check_eq("dev_addr", m_dev_addr, Dev);
            check_eq("cmd_expected", exp_cmd.size() > 0, 1);
            if (exp_cmd.size() > 0) begin
              e = exp_cmd.pop_front();
              check_eq("cmd_fields", got, e);
            end
          end
          stalled = !m_ready;
          prev = got;
        end else begin
          stalled = 0;
        end
        if (host_done) begin
          check_eq("host_done_expected", exp_host.size() > 0, 1);
          if (exp_host.size() > 0) begin
            eh = exp_host.pop_front();
            check_eq("host_err", host_err, eh);
          end
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 4000; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check_eq({tag, "_reaches_idle"}, busy, 0);
  endtask

  // Leaves reset asserted with the model planned; caller releases it on a negedge.
  task automatic boot_start();
    reset = 1;
    hold_ready = 0;
    spurious_req = 0;
    exp_cmd.delete();
    exp_host.delete();
    resp_q.delete();
    @(negedge clk);
    @(negedge clk);
    plan_boot();
  endtask

  task automatic release_and_time(output int cyc);
    reset = 0;
    cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (m_valid) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic finish_boot(input string tag);
    wait_idle(tag);
    repeat (2) @(negedge clk);
    check_eq({tag, "_boot_done"}, boot_done, exp_bd);
    check_eq({tag, "_boot_error"}, boot_error, exp_be);
    check_eq({tag, "_cmds_left"}, exp_cmd.size(), 0);
  endtask

  task automatic host_write(input logic [15:0] a, input logic [7:0] d, input int nk,
                            output bit bd_at_ready);
    bit got;
    for (int k = 0; k <= nk && k <= MaxRetry; k++) begin
      exp_cmd.push_back({a, d});
      resp_q.push_back(k < nk);
    end
    exp_host.push_back(nk > MaxRetry);
    host_valid = 1;
    host_reg_addr = a;
    host_reg_data = d;
    got = 0;
    bd_at_ready = 0;
    for (int c = 0; c < 4000; c++) begin
      if (host_ready) begin
        got = 1;
        bd_at_ready = boot_done | boot_error;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    host_valid = 0;
    check_eq("host_accepted", got, 1);
    wait_idle("host");
    repeat (2) @(negedge clk);
    check_eq("host_cmds_left", exp_cmd.size(), 0);
    check_eq("host_done_seen", exp_host.size(), 0);
  endtask

  task automatic load_rom3(input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2,
                           input logic [23:0] e3);
    for (int i = 0; i < Depth; i++) begin
      rom[i] = 24'hFFFF00;
      nk_tab[i] = 0;
    end
    rom[0] = e0;
    rom[1] = e1;
    rom[2] = e2;
    rom[3] = e3;
  endtask

  initial begin : stim
    int cyc;
    bit bd;
    int len;
    host_valid = 0;
    host_reg_addr = '0;
    host_reg_data = '0;

    // Directed boot: two entries, end marker, always ACK, m_ready stalled 20 cycles.
    load_rom3(24'h400001, 24'h401501, 24'hFFFF00, 24'hFFFF00);
    boot_start();
    check_eq("rst_busy", busy, 1);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_rom_addr", rom_addr, 0);
    check_eq("rst_host_ready", host_ready, 0);
    check_eq("rst_boot_done", boot_done, 0);
    hold_ready = 20;
    release_and_time(cyc);
    check_eq("first_m_valid_cycle", cyc, 12);
    // Host request raised mid-boot must stall until boot completes.
    host_write(16'h4023, 8'hE7, 0, bd);
    check_eq("host_ready_only_after_boot", bd, 1);
    finish_boot("s1");
    check_eq("s1_busy", busy, 0);
    spurious_req = 1;
    repeat (4) @(negedge clk);
    check_eq("spurious_done_idle", busy, 0);
    check_eq("spurious_done_ready", host_ready, 1);

    // Entry 0 NACKed twice then ACKed.
    load_rom3(24'h400001, 24'h401501, 24'hFFFF00, 24'hFFFF00);
    nk_tab[0] = 2;
    boot_start();
    release_and_time(cyc);
    finish_boot("s2");

    // Entry 1 exhausts its retries; the rest of the table is abandoned; host still served.
    load_rom3(24'h400001, 24'h401501, 24'h401705, 24'hFFFF00);
    nk_tab[1] = 4;
    boot_start();
    release_and_time(cyc);
    finish_boot("s3");
    host_write(16'h4023, 8'hE7, 0, bd);
    host_write(16'h4024, 8'h12, 4, bd);

    // Reset while waiting on the second boot command.
    load_rom3(24'h400001, 24'h401501, 24'h401A0C, 24'hFFFF00);
    done_dly_min = 5;
    done_dly_max = 8;
    boot_start();
    accepts = 0;
    release_and_time(cyc);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #2;
      if (accepts >= 2) break;
    end
    check_eq("s4_second_accept", accepts >= 2, 1);
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    check_eq("async_m_valid", m_valid, 0);
    check_eq("async_rom_addr", rom_addr, 0);
    check_eq("async_m_reg_addr", m_reg_addr, 0);
    check_eq("async_m_data", m_data, 0);
    check_eq("async_busy", busy, 1);
    check_eq("async_host_ready", host_ready, 0);
    check_eq("async_status", {host_done, host_err, boot_done, boot_error}, 0);
    done_dly_min = 0;
    done_dly_max = 2;
    boot_start();
    check_eq("restart_rom_addr", rom_addr, 0);
    release_and_time(cyc);
    check_eq("restart_first_m_valid", cyc, 12);
    finish_boot("s4");

    // Randomized tables (first one fills every slot to exercise the end-of-ROM case).
    for (int it = 0; it < 6; it++) begin
      len = (it == 0) ? Depth : $urandom_range(0, Depth);
      for (int i = 0; i < Depth; i++) begin
        if (i < len) rom[i] = {16'($urandom_range(0, 16'hFFFE)), 8'($urandom_range(0, 255))};
        else rom[i] = {16'hFFFF, 8'($urandom_range(0, 255))};
        nk_tab[i] = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 4);
      end
      ready_mode = $urandom_range(0, 1);
      done_dly_max = $urandom_range(0, 3);
      boot_start();
      release_and_time(cyc);
      finish_boot("rand");
      for (int h = 0; h < 2; h++) begin
        host_write(16'($urandom_range(0, 16'hFFFF)), 8'($urandom_range(0, 255)),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, bd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
